// File: rtl/multi_cnt_if.sv
// Control and status bundle for the multi_cnt counter bank.
// An undriven delta keeps its DEFAULT_DELTA step in every channel.
interface multi_cnt_if #(
  parameter int NCH           = 2,
  parameter int WIDTH         = 4,
  parameter int DEFAULT_DELTA = 10
);
  localparam logic [WIDTH-1:0] DEF_STEP = WIDTH'(DEFAULT_DELTA);

  logic [NCH-1:0]       en;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] load_val;
  logic [NCH*WIDTH-1:0] delta = {NCH{DEF_STEP}};
  logic [NCH-1:0]       down;
  logic                 clr_ovf;
  logic [NCH*WIDTH-1:0] cnt;
  logic [NCH-1:0]       evt;
  logic [NCH-1:0]       ovf;

  modport master (
    output en, load, load_val, delta, down, clr_ovf,
    input  cnt, evt, ovf
  );

  modport slave (
    input  en, load, load_val, delta, down, clr_ovf,
    output cnt, evt, ovf
  );
endinterface

// File: rtl/multi_cnt.sv
// Bank of NCH independent WIDTH-bit up/down counters with wrap or saturate
// on over/underflow, a one-cycle event pulse and a sticky overflow flag.
module multi_cnt #(
  parameter int NCH      = 2,
  parameter int WIDTH    = 4,
  parameter int INITVAL  = 0,
  parameter int SATURATE = 0
) (
  input logic        clock,
  input logic        resetn,
  multi_cnt_if.slave bus
);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INITVAL);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_reg = INIT_VAL;
      logic [WIDTH-1:0] cnt_next;
      logic             evt_reg = 1'b0;
      logic             evt_next;
      logic             ovf_reg = 1'b0;
      logic             ovf_next;
      logic [WIDTH-1:0] step;
      logic [WIDTH:0]   sum;
      logic             flow;

      assign step = bus.delta[gi*WIDTH +: WIDTH];

      // The extra sum bit carries the overflow; underflow is a plain compare.
      always_comb begin
        sum      = '0;
        flow     = 1'b0;
        cnt_next = cnt_reg;
        evt_next = 1'b0;
        if (bus.down[gi]) begin
          sum  = {1'b0, cnt_reg} - {1'b0, step};
          flow = (cnt_reg < step);
        end else begin
          sum  = {1'b0, cnt_reg} + {1'b0, step};
          flow = sum[WIDTH];
        end
        if (bus.load[gi]) begin
          cnt_next = bus.load_val[gi*WIDTH +: WIDTH];
        end else if (bus.en[gi]) begin
          evt_next = flow;
          if (flow && (SATURATE != 0)) begin
            cnt_next = bus.down[gi] ? '0 : '1;
          end else begin
            cnt_next = sum[WIDTH-1:0];
          end
        end
        // A fresh event beats a simultaneous clear.
        ovf_next = evt_next | (ovf_reg & ~bus.clr_ovf);
      end

      always_ff @(posedge clock) begin
        if (!resetn) begin
          cnt_reg <= INIT_VAL;
          evt_reg <= 1'b0;
          ovf_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          evt_reg <= evt_next;
          ovf_reg <= ovf_next;
        end
      end

      assign bus.cnt[gi*WIDTH +: WIDTH] = cnt_reg;
      assign bus.evt[gi]                = evt_reg;
      assign bus.ovf[gi]                = ovf_reg;
    end
  endgenerate
endmodule

// File: tb/tb_multi_cnt.sv
// Scoreboard bench for multi_cnt: wrapping, saturating and default-step instances.
module tb_multi_cnt;
  localparam logic [1:0] DW = 2'd0;  // wrap instance
  localparam logic [1:0] DS = 2'd1;  // saturate instance
  localparam logic [1:0] DD = 2'd2;  // default-delta instance

  typedef struct packed {
    logic [1:0] dut;
    logic       ch;
    logic [5:0] exp;  // {cnt[3:0], evt, ovf}
  } sb_t;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;
  sb_t  sb[$];

  multi_cnt_if #(.NCH(2), .WIDTH(4), .DEFAULT_DELTA(10)) bw ();
  multi_cnt_if #(.NCH(2), .WIDTH(4), .DEFAULT_DELTA(10)) bs ();
  multi_cnt_if #(.NCH(2), .WIDTH(4), .DEFAULT_DELTA(10)) bd ();

  multi_cnt #(.NCH(2), .WIDTH(4), .INITVAL(1), .SATURATE(0)) u_wrap (
    .clock(clock), .resetn(resetn), .bus(bw)
  );
  multi_cnt #(.NCH(2), .WIDTH(4), .INITVAL(1), .SATURATE(1)) u_sat (
    .clock(clock), .resetn(resetn), .bus(bs)
  );
  multi_cnt #(.NCH(2), .WIDTH(4), .INITVAL(1), .SATURATE(0)) u_def (
    .clock(clock), .resetn(resetn), .bus(bd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] observe(input logic [1:0] dut, input logic ch);
    int c;
    c = int'(ch);
    case (dut)
      DW:      return {bw.cnt[c*4 +: 4], bw.evt[c], bw.ovf[c]};
      DS:      return {bs.cnt[c*4 +: 4], bs.evt[c], bs.ovf[c]};
      default: return {bd.cnt[c*4 +: 4], bd.evt[c], bd.ovf[c]};
    endcase
  endfunction

  task automatic push(input logic [1:0] dut, input int ch, input int c, input int e, input int o);
    sb_t t;
    t.dut = dut;
    t.ch  = 1'(ch);
    t.exp = {4'(c), 1'(e), 1'(o)};
    sb.push_back(t);
  endtask

  // Same stimulus to the wrap and saturate instances.
  task automatic drive(input logic [1:0] en, input logic [1:0] ld, input logic [7:0] lv,
                       input logic [7:0] dl, input logic [1:0] dn, input logic clr);
    bw.en = en; bw.load = ld; bw.load_val = lv; bw.delta = dl; bw.down = dn; bw.clr_ovf = clr;
    bs.en = en; bs.load = ld; bs.load_val = lv; bs.delta = dl; bs.down = dn; bs.clr_ovf = clr;
  endtask

  task automatic test_power_up;
    sb_t e;
    logic [5:0] got;
    #1;
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < 2; ch++) push(2'(d), ch, 1, 0, 0);
    $display("[test_power_up] cnt_w=%h cnt_s=%h cnt_d=%h", bw.cnt, bs.cnt, bd.cnt);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = observe(e.dut, e.ch);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL test_power_up dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                 e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  task automatic test_reset;
    sb_t e;
    logic [5:0] got;
    resetn = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < 2; ch++) push(2'(d), ch, 1, 0, 0);
    @(posedge clock); #1;
    $display("[test_reset] cnt_w=%h cnt_s=%h cnt_d=%h", bw.cnt, bs.cnt, bd.cnt);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = observe(e.dut, e.ch);
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL test_reset dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                 e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_count_up;
    sb_t e;
    logic [5:0] got;
    int wc[6] = '{4, 7, 10, 13, 0, 3};
    int we[6] = '{0, 0, 0, 0, 1, 0};
    int wo[6] = '{0, 0, 0, 0, 1, 1};
    int sc[6] = '{4, 7, 10, 13, 15, 15};
    int se[6] = '{0, 0, 0, 0, 1, 1};
    int so[6] = '{0, 0, 0, 0, 1, 1};
    for (int k = 0; k < 6; k++) begin
      drive(2'b01, 2'b00, 8'h00, 8'h03, 2'b00, 1'b0);
      push(DW, 0, wc[k], we[k], wo[k]);
      push(DS, 0, sc[k], se[k], so[k]);
      push(DW, 1, 1, 0, 0);
      push(DS, 1, 1, 0, 0);
      @(posedge clock); #1;
      $display("[test_count_up] step=%0d cnt_w=%h evt_w=%b cnt_s=%h evt_s=%b", k, bw.cnt, bw.evt, bs.cnt, bs.evt);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = observe(e.dut, e.ch);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL test_count_up step=%0d dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                   k, e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
        end
      end
    end
  endtask

  task automatic test_count_down;
    sb_t e;
    logic [5:0] got;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin drive(2'b00, 2'b01, 8'h02, 8'h00, 2'b00, 1'b0); push(DW, 0, 2, 0, 1);  push(DS, 0, 2, 0, 1); end
        1: begin drive(2'b01, 2'b00, 8'h00, 8'h05, 2'b01, 1'b0); push(DW, 0, 13, 1, 1); push(DS, 0, 0, 1, 1); end
        2: begin drive(2'b01, 2'b00, 8'h00, 8'h05, 2'b01, 1'b0); push(DW, 0, 8, 0, 1);  push(DS, 0, 0, 1, 1); end
        default: begin drive(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0); push(DW, 0, 8, 0, 1); push(DS, 0, 0, 0, 1); end
      endcase
      @(posedge clock); #1;
      $display("[test_count_down] step=%0d cnt_w=%h evt_w=%b cnt_s=%h evt_s=%b", k, bw.cnt, bw.evt, bs.cnt, bs.evt);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = observe(e.dut, e.ch);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL test_count_down step=%0d dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                   k, e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
        end
      end
    end
  endtask

  task automatic test_load_clr;
    sb_t e;
    logic [5:0] got;
    for (int k = 0; k < 3; k++) begin
      case (k)
        // load wins over a simultaneous enable
        0: begin drive(2'b01, 2'b01, 8'h07, 8'h03, 2'b00, 1'b0); push(DW, 0, 7, 0, 1); push(DS, 0, 7, 0, 1); end
        // event and clear in the same cycle: flag stays set
        1: begin
          drive(2'b01, 2'b00, 8'h00, 8'h09, 2'b00, 1'b1);
          push(DW, 0, 0, 1, 1); push(DS, 0, 15, 1, 1);
          push(DW, 1, 1, 0, 0); push(DS, 1, 1, 0, 0);
        end
        default: begin drive(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1); push(DW, 0, 0, 0, 0); push(DS, 0, 15, 0, 0); end
      endcase
      @(posedge clock); #1;
      $display("[test_load_clr] step=%0d cnt_w=%h ovf_w=%b cnt_s=%h ovf_s=%b", k, bw.cnt, bw.ovf, bs.cnt, bs.ovf);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = observe(e.dut, e.ch);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL test_load_clr step=%0d dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                   k, e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
        end
      end
    end
  endtask

  task automatic test_reset_midcount;
    sb_t e;
    logic [5:0] got;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          drive(2'b00, 2'b11, 8'hEE, 8'h00, 2'b00, 1'b0);
          for (int ch = 0; ch < 2; ch++) begin push(DW, ch, 14, 0, 0); push(DS, ch, 14, 0, 0); end
        end
        1: begin
          drive(2'b11, 2'b00, 8'h00, 8'hFF, 2'b00, 1'b0);
          for (int ch = 0; ch < 2; ch++) begin push(DW, ch, 13, 1, 1); push(DS, ch, 15, 1, 1); end
        end
        2: begin
          resetn = 1'b0;
          for (int d = 0; d < 3; d++)
            for (int ch = 0; ch < 2; ch++) push(2'(d), ch, 1, 0, 0);
        end
        default: begin
          resetn = 1'b1;
          drive(2'b11, 2'b00, 8'h00, 8'h22, 2'b00, 1'b0);
          for (int ch = 0; ch < 2; ch++) begin push(DW, ch, 3, 0, 0); push(DS, ch, 3, 0, 0); end
        end
      endcase
      @(posedge clock); #1;
      $display("[test_reset_midcount] step=%0d cnt_w=%h ovf_w=%b cnt_s=%h ovf_s=%b", k, bw.cnt, bw.ovf, bs.cnt, bs.ovf);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = observe(e.dut, e.ch);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL test_reset_midcount step=%0d dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                   k, e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
        end
      end
    end
  endtask

  task automatic test_default_delta;
    sb_t e;
    logic [5:0] got;
    int dc[3] = '{11, 5, 5};
    int de[3] = '{0, 1, 0};
    int dov[3] = '{0, 1, 1};
    drive(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bd.en = (k < 2) ? 2'b10 : 2'b00;
      push(DD, 1, dc[k], de[k], dov[k]);
      push(DD, 0, 1, 0, 0);
      @(posedge clock); #1;
      $display("[test_default_delta] step=%0d cnt_d=%h evt_d=%b ovf_d=%b", k, bd.cnt, bd.evt, bd.ovf);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        got = observe(e.dut, e.ch);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL test_default_delta step=%0d dut=%0d ch=%0d cnt=%0d evt=%b ovf=%b required cnt=%0d evt=%b ovf=%b",
                   k, e.dut, e.ch, got[5:2], got[1], got[0], e.exp[5:2], e.exp[1], e.exp[0]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b1;
    drive(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    bd.en = 2'b00; bd.load = 2'b00; bd.load_val = 8'h00; bd.down = 2'b00; bd.clr_ovf = 1'b0;

    test_power_up();
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clr();
    test_reset_midcount();
    test_default_delta();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
